// File: rtl/aibcr3_dcc_pkg.sv
// Shared types for the DCC delay-line calibration controller.
package aibcr3_dcc_pkg;

    // Default delay code width; must match the delay-line gray bus.
    localparam int CODE_W_DEF = 11;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DECIDE = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } dcc_state_e;

    // Search mode: successive approximation first, then linear tracking.
    typedef enum logic {
        MODE_SAR   = 1'b0,
        MODE_TRACK = 1'b1
    } dcc_mode_e;

endpackage

// File: rtl/aibcr3_dcc_bin2gray.sv
// Registered binary-to-gray converter with synchronous active-high reset.
module aibcr3_dcc_bin2gray
    import aibcr3_dcc_pkg::*;
#(
    parameter int W = CODE_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    logic [W-1:0] r_gray;

    // Register the gray encoding so the delay line sees glitch-free code changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray <= {W{1'b0}};
        end else begin
            r_gray <= i_bin ^ (i_bin >> 1);
        end
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/aibcr3_dcc_dll_ctrl.sv
// DCC delay-line calibration controller: SAR search, linear tracking until
// the code dithers, then freeze and lock.
module aibcr3_dcc_dll_ctrl
    import aibcr3_dcc_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int SETTLE_CYC = 4,
    parameter int PD_WAIT    = 4,
    parameter int LOCK_CNT   = 4,
    parameter int MAX_TRACK  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pd_late,
    output logic [CODE_W-1:0] gray,
    output logic [CODE_W-1:0] code_bin,
    output logic              launch,
    output logic              measure,
    output logic              dll_lock,
    output logic              busy,
    output logic              lock_err
);

    localparam int CNT_W  = 8;
    localparam int IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int REV_W  = $clog2(LOCK_CNT + 1);
    localparam int STEP_W = $clog2(MAX_TRACK + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(PD_WAIT - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(CODE_W - 1);
    localparam logic [REV_W-1:0]  REV_LOCK    = REV_W'(LOCK_CNT);
    localparam logic [STEP_W-1:0] STEP_LIMIT  = STEP_W'(MAX_TRACK);
    localparam logic [CODE_W-1:0] CODE_ZERO   = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] CODE_MID    = {1'b1, {(CODE_W-1){1'b0}}};

    dcc_state_e        r_state;
    dcc_mode_e         r_mode;
    logic [CODE_W-1:0] r_code;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [REV_W-1:0]  r_rev_cnt;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_prev_dir_up;
    logic              r_prev_valid;
    logic              r_launch;
    logic              r_measure;
    logic              r_lock;
    logic              r_busy;
    logic              r_err;

    logic [CODE_W-1:0] w_bit_cur;
    logic [CODE_W-1:0] w_sar_code;
    logic [CODE_W-1:0] w_trk_code;
    logic              w_dir_up;
    logic [REV_W-1:0]  w_rev_next;
    logic [STEP_W-1:0] w_step_next;

    // Next code candidates for a SAR decision and a tracking decision.
    always_comb begin
        w_bit_cur   = CODE_ONE << r_idx;
        w_sar_code  = r_code;
        w_trk_code  = r_code;
        w_dir_up    = ~pd_late;
        w_rev_next  = r_rev_cnt;
        w_step_next = r_step_cnt + STEP_W'(1);

        // Delayed edge late: trial bit was too large, drop it.
        if (pd_late) begin
            w_sar_code = w_sar_code & ~w_bit_cur;
        end else begin
            w_sar_code = w_sar_code;
        end
        // Try the next lower bit, if any remain.
        if (r_idx != {IDX_W{1'b0}}) begin
            w_sar_code = w_sar_code | (w_bit_cur >> 1);
        end else begin
            w_sar_code = w_sar_code;
        end

        // Tracking step saturates at both ends but keeps its direction.
        if (pd_late) begin
            if (r_code == CODE_ZERO) begin
                w_trk_code = r_code;
            end else begin
                w_trk_code = r_code - CODE_ONE;
            end
        end else begin
            if (r_code == CODE_MAX) begin
                w_trk_code = r_code;
            end else begin
                w_trk_code = r_code + CODE_ONE;
            end
        end

        if (r_prev_valid && (r_prev_dir_up != w_dir_up)) begin
            w_rev_next = r_rev_cnt + REV_W'(1);
        end else begin
            w_rev_next = r_rev_cnt;
        end
    end

    // Calibration FSM with registered pulse, lock, busy and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_SAR;
            r_code        <= CODE_ZERO;
            r_cnt         <= {CNT_W{1'b0}};
            r_idx         <= {IDX_W{1'b0}};
            r_rev_cnt     <= {REV_W{1'b0}};
            r_step_cnt    <= {STEP_W{1'b0}};
            r_prev_dir_up <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_launch      <= 1'b0;
            r_measure     <= 1'b0;
            r_lock        <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else if (!enable) begin
            // Abort: back to idle with a zero code; the error flag stays sticky.
            r_state       <= ST_IDLE;
            r_mode        <= MODE_SAR;
            r_code        <= CODE_ZERO;
            r_cnt         <= {CNT_W{1'b0}};
            r_idx         <= {IDX_W{1'b0}};
            r_rev_cnt     <= {REV_W{1'b0}};
            r_step_cnt    <= {STEP_W{1'b0}};
            r_prev_dir_up <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_launch      <= 1'b0;
            r_measure     <= 1'b0;
            r_lock        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_code  <= CODE_MID;
                    r_idx   <= IDX_TOP;
                    r_mode  <= MODE_SAR;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_busy  <= 1'b1;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt     <= {CNT_W{1'b0}};
                        r_launch  <= 1'b1;
                        r_measure <= 1'b1;
                        r_state   <= ST_LAUNCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_launch  <= 1'b0;
                    r_measure <= 1'b0;
                    r_cnt     <= {CNT_W{1'b0}};
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (r_mode == MODE_SAR) begin
                        r_code <= w_sar_code;
                        if (r_idx != {IDX_W{1'b0}}) begin
                            r_idx <= r_idx - IDX_W'(1);
                        end else begin
                            r_mode       <= MODE_TRACK;
                            r_rev_cnt    <= {REV_W{1'b0}};
                            r_step_cnt   <= {STEP_W{1'b0}};
                            r_prev_valid <= 1'b0;
                        end
                        r_state <= ST_SETTLE;
                    end else begin
                        r_code        <= w_trk_code;
                        r_prev_dir_up <= w_dir_up;
                        r_prev_valid  <= 1'b1;
                        r_rev_cnt     <= w_rev_next;
                        r_step_cnt    <= w_step_next;
                        if (w_rev_next == REV_LOCK) begin
                            r_lock  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_LOCKED;
                        end else if (w_step_next == STEP_LIMIT) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FAIL;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_LOCKED: begin
                    r_state <= ST_LOCKED;
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    aibcr3_dcc_bin2gray #(
        .W(CODE_W)
    ) u_bin2gray (
        .clk    (clk),
        .rst    (rst),
        .i_bin  (r_code),
        .o_gray (gray)
    );

    assign code_bin = r_code;
    assign launch   = r_launch;
    assign measure  = r_measure;
    assign dll_lock = r_lock;
    assign busy     = r_busy;
    assign lock_err = r_err;

endmodule
